mult_share_arbiter: RTL

Time-shares one fixed-point signed multiplier among NumReq requesters, e.g. the lifting-step units of the DWT datapath. A round-robin arbiter grants at most one requester per cycle. Operands pass through a 2-stage registered pipeline: operand register, then multiply and result register. Each result returns on a single valid/ready output stream, tagged with the requester's index.

---
 rtl/mult_share_pkg.sv | 34 +++
 rtl/mult_share_arbiter_rr_arbiter.sv | 32 +++
 rtl/mult_share_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/mult_share_pkg.sv
// Shared helpers for mult_share_arbiter: result scaling, id width, and the
// MULT_SAT_EN build option (saturate instead of wrap on result overflow).
package mult_share_pkg;

`ifdef MULT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    function automatic int calc_lsb(input int in_point, input int out_point);
        return 2 * in_point - out_point;
    endfunction

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Arithmetic shift floors toward -inf; the caller keeps the low w bits,
    // which wraps unless the clamp below is compiled in.
    function automatic logic signed [63:0] scale_prod(input logic signed [63:0] p,
                                                      input int lsb, input int w);
        logic signed [63:0] sh, hi, lo;
        sh = p >>> lsb;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (SAT_EN) begin
            if (sh > hi)      sh = hi;
            else if (sh < lo) sh = lo;
        end
        return sh;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps modulo N;
// the first active request wins. The caller owns and advances ptr.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = id_w(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] winner
);

    always_comb begin
        int  idx;
        logic found;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// One signed fixed-point multiplier time-shared by NumReq requesters through a
// round-robin grant and a 2-stage pipeline. Build option: MULT_SAT_EN.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int Width    = 16,
    parameter int InPoint  = 10,
    parameter int OutPoint = 10,
    parameter int NumReq   = 4,
    localparam int IDW     = id_w(NumReq)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_valid_i,
    input  logic [NumReq*Width-1:0]   req_a_i,
    input  logic [NumReq*Width-1:0]   req_b_i,
    output logic [NumReq-1:0]         req_ready_o,
    output logic                      res_valid_o,
    output logic [Width-1:0]          res_data_o,
    output logic [IDW-1:0]            res_id_o,
    input  logic                      res_ready_i
);

    localparam int LSB    = calc_lsb(InPoint, OutPoint);
    localparam int STAGES = 2;

    if (LSB < 0 || LSB + Width > 2 * Width || Width > 32 || NumReq < 2) begin : g_bad_cfg
        $error("mult_share_arbiter: unsupported Width/InPoint/OutPoint/NumReq");
    end

    logic [NumReq-1:0][Width-1:0] a_arr, b_arr;
    logic [STAGES:1]              vld_pipe;
    logic [NumReq-1:0]            gnt;
    logic [IDW-1:0]               ptr, win, s1_id;
    logic [Width-1:0]             s1_a, s1_b, res_next;
    logic signed [2*Width-1:0]    ea, eb, prod;
    logic signed [63:0]           scaled;
    logic                         adv1, adv2, acc, unused_hi;

    assign a_arr = req_a_i;
    assign b_arr = req_b_i;

    rr_arbiter #(.N(NumReq)) u_arb (
        .req    (req_valid_i),
        .ptr    (ptr),
        .grant  (gnt),
        .winner (win)
    );

    assign res_valid_o = vld_pipe[2];
    assign adv2        = !vld_pipe[2] || res_ready_i;
    assign adv1        = !vld_pipe[1] || adv2;
    assign req_ready_o = (adv1 && !rst_i) ? gnt : '0;
    assign acc         = |req_ready_o;

    // Stage-2 combinational multiply and scaling of the stage-1 operands.
    assign ea        = {{Width{s1_a[Width-1]}}, s1_a};
    assign eb        = {{Width{s1_b[Width-1]}}, s1_b};
    assign prod      = ea * eb;
    assign scaled    = scale_prod(64'(prod), LSB, Width);
    assign res_next  = scaled[Width-1:0];
    assign unused_hi = ^scaled[63:Width];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (acc) begin
            ptr <= (win == IDW'(NumReq - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe[1] <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_id       <= '0;
        end else if (adv1) begin
            vld_pipe[1] <= acc;
            if (acc) begin
                s1_a  <= a_arr[win];
                s1_b  <= b_arr[win];
                s1_id <= win;
            end
        end
    end

    // Output register only loads on adv2, so data/id hold under backpressure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe[2] <= 1'b0;
            res_data_o  <= '0;
            res_id_o    <= '0;
        end else if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                res_data_o <= res_next;
                res_id_o   <= s1_id;
            end
        end
    end

endmodule
